// File: rtl/rf_write_arbiter_if.sv
// Bus bundle between the writeback sources, the hazard unit and rf_write_arbiter.
// CW must equal $clog2(DEPTH+1) of the arbiter instance.
interface rf_write_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 3
);
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          lu_valid;
    logic          lu_ready;
    logic [AW-1:0] lu_addr;
    logic [DW-1:0] lu_data;
    logic [AW-1:0] A3;
    logic [DW-1:0] WD3;
    logic          WE3;
    logic [AW-1:0] rd_a1;
    logic [AW-1:0] rd_a2;
    logic          pend_a1;
    logic          pend_a2;
    logic [CW-1:0] fifo_count;
    logic          wb_stall;

    modport master (
        output wb_we, wb_addr, wb_data, lu_valid, lu_addr, lu_data, rd_a1, rd_a2,
        input  lu_ready, A3, WD3, WE3, pend_a1, pend_a2, fifo_count, wb_stall
    );

    modport slave (
        input  wb_we, wb_addr, wb_data, lu_valid, lu_addr, lu_data, rd_a1, rd_a2,
        output lu_ready, A3, WD3, WE3, pend_a1, pend_a2, fifo_count, wb_stall
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Merges pipeline WB writes and queued long-latency results onto the RF write port.
// Optional starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module rf_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int DW           = 32,
    parameter int AW           = 5,
    parameter int STARVE_LIMIT = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    rf_write_arbiter_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] live_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic [AW-1:0]    a3_q;
    logic [DW-1:0]    wd3_q;
    logic             we3_q;
    logic             stall_q;

    logic             empty;
    logic             lu_xfer;
    logic             wb_win;
    logic             lu_keep;
    logic             pop;
    logic             bypass;
    logic             push;
    logic             pend1;
    logic             pend2;

    // A result aimed at r0 or at the register the pipeline writes this cycle is stale: accept and drop it.
    always_comb begin
        empty   = (count == '0);
        lu_xfer = bus.lu_valid && (count < FULL_CNT);
        wb_win  = bus.wb_we && (bus.wb_addr != '0) && !stall_q;
        lu_keep = lu_xfer && (bus.lu_addr != '0) && !(wb_win && (bus.lu_addr == bus.wb_addr));
        pop     = !wb_win && !empty;
        bypass  = !wb_win && empty && lu_keep;
        push    = lu_keep && !bypass;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            live_q <= '0;
            a3_q   <= '0;
            wd3_q  <= '0;
            we3_q  <= 1'b0;
        end else begin
            if (wb_win) begin
                a3_q  <= bus.wb_addr;
                wd3_q <= bus.wb_data;
                we3_q <= 1'b1;
            end else if (pop) begin
                a3_q  <= addr_q[rd_ptr];
                wd3_q <= data_q[rd_ptr];
                we3_q <= live_q[rd_ptr];
            end else if (bypass) begin
                a3_q  <= bus.lu_addr;
                wd3_q <= bus.lu_data;
                we3_q <= 1'b1;
            end else begin
                we3_q <= 1'b0;
            end

            if (wb_win) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (addr_q[i] == bus.wb_addr) live_q[i] <= 1'b0;
                end
            end
            // Live bits are cleared on pop so a set bit always implies an occupied slot.
            if (pop) begin
                live_q[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + PW'(1);
            end
            if (push) begin
                live_q[wr_ptr] <= 1'b1;
                wr_ptr         <= wr_ptr + PW'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            addr_q[wr_ptr] <= bus.lu_addr;
            data_q[wr_ptr] <= bus.lu_data;
        end
    end

    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (addr_q[i] == bus.rd_a1) && (bus.rd_a1 != '0)) pend1 = 1'b1;
            if (live_q[i] && (addr_q[i] == bus.rd_a2) && (bus.rd_a2 != '0)) pend2 = 1'b1;
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_tmr;

    // Down-counter reloaded on every pop; terminal count forces one head pop via wb_stall.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            starve_tmr <= SW'(STARVE_LIMIT);
            stall_q    <= 1'b0;
        end else begin
            stall_q <= 1'b0;
            if (pop) begin
                starve_tmr <= SW'(STARVE_LIMIT);
            end else if (!empty && (starve_tmr != '0)) begin
                starve_tmr <= starve_tmr - SW'(1);
                if (starve_tmr == SW'(1)) stall_q <= 1'b1;
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = |STARVE_LIMIT;
    assign stall_q    = 1'b0;
`endif

    assign bus.lu_ready   = (count < FULL_CNT);
    assign bus.A3         = a3_q;
    assign bus.WD3        = wd3_q;
    assign bus.WE3        = we3_q;
    assign bus.pend_a1    = pend1;
    assign bus.pend_a2    = pend2;
    assign bus.fifo_count = count;
    assign bus.wb_stall   = stall_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter (default build, starvation guard off).
module tb_rf_write_arbiter;
    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int CW    = 3;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    rf_write_arbiter_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();

    rf_write_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW), .STARVE_LIMIT(8)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            live;
    } ent_t;

    ent_t          mq[$];
    logic [AW-1:0] m_a3;
    logic [DW-1:0] m_wd3;
    logic          m_we3;
    logic [DW-1:0] rf [32];
    int            n_tests = 0;
    int            n_fail  = 0;

    always @(negedge CLK) begin
        if (bus.WE3 === 1'b1) rf[bus.A3] = bus.WD3;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit mpend(input logic [AW-1:0] a);
        foreach (mq[i]) if (mq[i].live && mq[i].addr == a && a != '0) return 1'b1;
        return 1'b0;
    endfunction

    // Reference behaviour for one rising edge, from the current inputs.
    function automatic void model_edge();
        bit   xfer;
        bit   wbw;
        ent_t e;
        ent_t h;
        if (RESET) begin
            mq.delete();
            m_a3  = '0;
            m_wd3 = '0;
            m_we3 = 1'b0;
            return;
        end
        xfer   = bus.lu_valid && (mq.size() < DEPTH);
        wbw    = bus.wb_we && (bus.wb_addr != '0);
        e.addr = bus.lu_addr;
        e.data = bus.lu_data;
        e.live = 1'b1;
        if (wbw) begin
            m_a3  = bus.wb_addr;
            m_wd3 = bus.wb_data;
            m_we3 = 1'b1;
            foreach (mq[i]) if (mq[i].addr == bus.wb_addr) mq[i].live = 1'b0;
            if (xfer && bus.lu_addr != '0 && bus.lu_addr != bus.wb_addr) mq.push_back(e);
        end else if (mq.size() != 0) begin
            h     = mq.pop_front();
            m_a3  = h.addr;
            m_wd3 = h.data;
            m_we3 = h.live;
            if (xfer && bus.lu_addr != '0) mq.push_back(e);
        end else if (xfer && bus.lu_addr != '0) begin
            m_a3  = bus.lu_addr;
            m_wd3 = bus.lu_data;
            m_we3 = 1'b1;
        end else begin
            m_we3 = 1'b0;
        end
    endfunction

    task automatic check_all();
        check("we3",     32'(bus.WE3),        32'(m_we3));
        check("a3",      32'(bus.A3),         32'(m_a3));
        check("wd3",     bus.WD3,             m_wd3);
        check("count",   32'(bus.fifo_count), 32'(mq.size()));
        check("ready",   32'(bus.lu_ready),   32'(mq.size() < DEPTH));
        check("pend_a1", 32'(bus.pend_a1),    32'(mpend(bus.rd_a1)));
        check("pend_a2", 32'(bus.pend_a2),    32'(mpend(bus.rd_a2)));
        check("stall",   32'(bus.wb_stall),   32'(0));
    endtask

    task automatic step();
        model_edge();
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld);
        bus.wb_we    = we;
        bus.wb_addr  = wa;
        bus.wb_data  = wd;
        bus.lu_valid = lv;
        bus.lu_addr  = la;
        bus.lu_data  = ld;
    endtask

    initial begin
        int idx;
        bit acc;
        foreach (rf[i]) rf[i] = '0;
        m_a3  = '0;
        m_wd3 = '0;
        m_we3 = 1'b0;
        RESET = 1'b1;
        bus.rd_a1 = '0;
        bus.rd_a2 = '0;
        drive(1'b1, 5'd5, 32'hDEAD, 1'b0, 5'd0, 32'h0);
        step();
        step();
        check("rst_we3",   32'(bus.WE3),        32'(0));
        check("rst_a3",    32'(bus.A3),         32'(0));
        check("rst_wd3",   bus.WD3,             32'(0));
        check("rst_count", 32'(bus.fifo_count), 32'(0));
        check("rst_ready", 32'(bus.lu_ready),   32'(1));
        RESET = 1'b0;

        drive(1'b1, 5'd8, 32'h0000_1234, 1'b0, 5'd0, 32'h0);
        step();
        check("wb_a3",  32'(bus.A3),  32'(8));
        check("wb_wd3", bus.WD3,      32'h0000_1234);
        check("wb_we3", 32'(bus.WE3), 32'(1));
        drive(1'b1, 5'd0, 32'h5555, 1'b0, 5'd0, 32'h0);
        step();
        check("wb_r0_we3", 32'(bus.WE3), 32'(0));

        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd16, 32'hA5A5_A5A5);
        step();
        check("byp_we3",   32'(bus.WE3),        32'(1));
        check("byp_a3",    32'(bus.A3),         32'(16));
        check("byp_count", 32'(bus.fifo_count), 32'(0));

        // Fill while the pipeline keeps the port busy.
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd17, 32'h117);
        idx = 0;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            acc = (mq.size() < DEPTH);
            step();
            if (acc) begin
                idx++;
                bus.lu_addr = 5'(17 + idx);
                bus.lu_data = 32'(32'h100 + 17 + idx);
            end
        end
        check("fill_accepted", 32'(idx), 32'(4));
        bus.rd_a1 = 5'd19;
        step();
        check("full_ready", 32'(bus.lu_ready),   32'(0));
        check("full_count", 32'(bus.fifo_count), 32'(4));
        check("pend19",     32'(bus.pend_a1),    32'(1));

        bus.wb_we = 1'b0;
        for (int k = 0; k < 5; k++) begin
            acc = bus.lu_valid && (mq.size() < DEPTH);
            step();
            if (acc) bus.lu_valid = 1'b0;
            check("drain_we3", 32'(bus.WE3), 32'(1));
            check("drain_a3",  32'(bus.A3),  32'(17 + k));
        end
        step();
        check("idle_we3", 32'(bus.WE3), 32'(0));

        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd17, 32'h1);
        bus.rd_a1 = 5'd17;
        step();
        check("kill_pend_before", 32'(bus.pend_a1), 32'(1));
        drive(1'b1, 5'd17, 32'h2, 1'b0, 5'd0, 32'h0);
        step();
        check("kill_pend_after", 32'(bus.pend_a1), 32'(0));
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        check("kill_slot_we3", 32'(bus.WE3), 32'(0));
        check("kill_slot_a3",  32'(bus.A3),  32'(17));
        step();
        check("rf17", rf[17], 32'h2);

        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd3, 32'h33, 1'b1, 5'(9 + k), 32'(32'h900 + k));
            step();
        end
        check("mid_count", 32'(bus.fifo_count), 32'(3));
        RESET = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        RESET = 1'b0;
        check("mid_rst_count", 32'(bus.fifo_count), 32'(0));
        for (int k = 0; k < 4; k++) begin
            step();
            check("post_rst_we3", 32'(bus.WE3), 32'(0));
        end

        for (int c = 0; c < 400; c++) begin
            RESET = ($urandom_range(0, 60) == 0);
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom);
            bus.rd_a1 = 5'($urandom_range(0, 7));
            bus.rd_a2 = 5'($urandom_range(0, 7));
            step();
        end
        RESET = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
